// File: rtl/pipelined_wallace_multiplier.sv
// Elastic, parametrised Wallace-tree multiplier with per-transaction signed/unsigned mode.
// Rank 1 takes magnitudes, middle ranks reduce partial products, last rank adds and fixes sign.
module pipelined_wallace_multiplier #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 3
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_z
);

  // Spare rows keep every unrolled CSA index in range for any WIDTH.
  localparam int unsigned ROWS = WIDTH + 3;

  typedef logic [2*WIDTH-1:0]           row_t;
  typedef logic [ROWS-1:0][2*WIDTH-1:0] rows_t;

  function automatic int rows_at(input int lvl);
    int n;
    n = int'(WIDTH);
    for (int i = 0; i < 64; i++) begin
      if (i < lvl) n = 2 * (n / 3) + n % 3;
    end
    return n;
  endfunction

  function automatic int num_levels();
    int n;
    int lv;
    n  = int'(WIDTH);
    lv = 0;
    for (int i = 0; i < 64; i++) begin
      if (n > 2) begin
        n  = 2 * (n / 3) + n % 3;
        lv = lv + 1;
      end
    end
    return lv;
  endfunction

  localparam int LEVELS = num_levels();
  localparam int MID    = int'(STAGES) - 2;

  // One 3:2 level: each full group of three rows becomes sum + shifted carry,
  // the 0..2 leftover rows pass straight through.
  function automatic rows_t csa_level(input rows_t r, input int n);
    rows_t o;
    int    g;
    o = '0;
    g = n / 3;
    for (int i = 0; i <= int'(WIDTH) / 3; i++) begin
      if (i < g) begin
        o[2*i]   = r[3*i] ^ r[3*i+1] ^ r[3*i+2];
        o[2*i+1] = ((r[3*i] & r[3*i+1]) | (r[3*i] & r[3*i+2]) | (r[3*i+1] & r[3*i+2])) << 1;
      end else if (i == g) begin
        if (n % 3 > 0) o[2*i]   = r[3*i];
        if (n % 3 > 1) o[2*i+1] = r[3*i+1];
      end
    end
    return o;
  endfunction

  function automatic rows_t reduce_range(input rows_t r, input int lo, input int hi);
    rows_t t;
    t = r;
    for (int l = 0; l < LEVELS; l++) begin
      if (l >= lo && l < hi) t = csa_level(t, rows_at(l));
    end
    return t;
  endfunction

  function automatic row_t cpa(input rows_t r);
    return r[0] + r[1];
  endfunction

  // Flow control: rank r may load when it or any rank downstream is empty, or the sink takes.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] en;

  always_comb begin : p_flow
    logic acc;
    acc = out_ready;
    ld  = '0;
    for (int r = int'(STAGES) - 1; r >= 0; r--) begin
      acc   = acc | ~v_q[r];
      ld[r] = acc;
    end
  end

  assign v_in      = {v_q[STAGES-2:0], in_valid};
  assign en        = v_in & ld;
  assign in_ready  = ld[0];
  assign out_valid = v_q[STAGES-1];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) v_q <= '0;
    else        v_q <= (v_in & ld) | (v_q & ~ld);
  end

  // Rank 1: magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits.
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             sign_in;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sign0_q;

  assign a_mag   = (in_signed & in_a[WIDTH-1]) ? -in_a : in_a;
  assign b_mag   = (in_signed & in_b[WIDTH-1]) ? -in_b : in_b;
  assign sign_in = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      a_q     <= '0;
      b_q     <= '0;
      sign0_q <= 1'b0;
    end else if (en[0]) begin
      a_q     <= a_mag;
      b_q     <= b_mag;
      sign0_q <= sign_in;
    end
  end

  rows_t pp;
  always_comb begin
    pp = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pp[i] = b_q[i] ? (row_t'(a_q) << i) : '0;
    end
  end

  // Middle ranks: tree levels [j*LEVELS/MID, (j+1)*LEVELS/MID) in rank j.
  rows_t tail_rows;
  logic  tail_sign;

  for (genvar j = 0; j < MID; j++) begin : g_rank
    localparam int LO = (j * LEVELS) / MID;
    localparam int HI = ((j + 1) * LEVELS) / MID;
    rows_t d, q;
    logic  s_q;
    logic  s_prev;
    if (j == 0) begin : g_src
      assign d      = reduce_range(pp, LO, HI);
      assign s_prev = sign0_q;
    end else begin : g_src
      assign d      = reduce_range(g_rank[j-1].q, LO, HI);
      assign s_prev = g_rank[j-1].s_q;
    end
    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        q   <= '0;
        s_q <= 1'b0;
      end else if (en[j+1]) begin
        q   <= d;
        s_q <= s_prev;
      end
    end
  end

  if (MID > 0) begin : g_tail_reg
    assign tail_rows = g_rank[MID-1].q;
    assign tail_sign = g_rank[MID-1].s_q;
  end else begin : g_tail_comb
    assign tail_rows = reduce_range(pp, 0, LEVELS);
    assign tail_sign = sign0_q;
  end

  // Last rank: carry-propagate add, then negate; -0 is 0 in two's complement.
  row_t sum, z_d, z_q;
  assign sum   = cpa(tail_rows);
  assign z_d   = tail_sign ? -sum : sum;
  assign out_z = z_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)          z_q <= '0;
    else if (en[STAGES-1]) z_q <= z_d;
  end

endmodule

// File: tb/tb_pipelined_wallace_multiplier.sv
// Scoreboard bench: three DUT configurations run in parallel against an arithmetic model.
module tb_pipelined_wallace_multiplier;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int W = (g == 0) ? 32 : (g == 1) ? 8 : 16;
    localparam int S = (g == 0) ? 3 : (g == 1) ? 2 : 5;

    logic           RESET     = 1'b0;
    logic           in_valid  = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a      = '0;
    logic [W-1:0]   in_b      = '0;
    logic           in_signed = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] out_z;

    logic [2*W-1:0] exp_q[$];
    int             pop_cyc[$];
    int             last_in_cyc = 0;
    bit             done = 1'b0;

    pipelined_wallace_multiplier #(.WIDTH(W), .STAGES(S)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_signed(in_signed),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_z    (out_z)
    );

    // Reference: extend to 2W bits by mode and multiply; truncation is exact modulo 2^(2W).
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
      logic [2*W-1:0] ea, eb;
      ea = {{W{s & a[W-1]}}, a};
      eb = {{W{s & b[W-1]}}, b};
      return ea * eb;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cfg%0d(W=%0d,S=%0d) %s: got %h expected %h", g, W, S, name, got, want);
      end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output bit waited);
      int t;
      t = 0;
      waited = 1'b0;
      in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
      @(negedge CLK);
      while (!in_ready && t < 200) begin
        waited = 1'b1;
        t++;
        @(negedge CLK);
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL cfg%0d issue_timeout: in_ready got 0 expected 1", g);
      end else begin
        exp_q.push_back(model(a, b, s));
        last_in_cyc = cyc + 1;
      end
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
    endtask

    task automatic issue_rand(input bit nonzero, output bit waited);
      logic [W-1:0] a, b;
      a = W'($urandom());
      b = W'($urandom());
      if (nonzero) begin
        a = a | W'(1);
        b = b | W'(1);
      end
      issue(a, b, 1'($urandom_range(0, 1)), waited);
    endtask

    task automatic wait_pops(input int n);
      int t;
      t = 0;
      while (pop_cyc.size() < n && t < 500) begin
        @(negedge CLK);
        t++;
      end
    endtask

    task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
        @(negedge CLK);
        t++;
      end
      check("drain_pending", 128'(exp_q.size()), 128'(0));
      @(posedge CLK);
      #1;
    endtask

    // Monitor: every output transfer must match the oldest outstanding expectation.
    always @(negedge CLK) begin
      if (RESET && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cfg%0d unexpected_output: got %h expected no output", g, out_z);
        end else begin
          check("product", 128'(out_z), 128'(exp_q.pop_front()));
        end
        pop_cyc.push_back(cyc);
      end
    end

    initial begin
      bit           w;
      bit           ok;
      int           n_fill;
      logic [W-1:0] mn, ones;
      mn = '0;
      mn[W-1] = 1'b1;
      ones = '1;
      n_fill = (S < 3) ? S : 3;

      // Reset state
      #2;
      check("reset_out_valid", 128'(out_valid), 128'(0));
      check("reset_out_z", 128'(out_z), 128'(0));
      repeat (2) @(negedge CLK);
      RESET = 1'b1;
      #1;
      check("reset_in_ready", 128'(in_ready), 128'(1));
      @(posedge CLK);
      #1;

      // Single transaction latency
      pop_cyc.delete();
      issue(W'(-5), W'(7), 1'b1, w);
      wait_pops(1);
      if (pop_cyc.size() > 0) check("latency", 128'(pop_cyc[0] - last_in_cyc), 128'(S - 1));
      else check("latency_no_output", 128'(0), 128'(1));
      wait_drain();

      // Corner products
      issue(mn, mn, 1'b1, w);
      issue(ones, ones, 1'b1, w);
      issue(ones, ones, 1'b0, w);
      issue('0, mn, 1'b1, w);
      issue(mn, ones, 1'b0, w);
      wait_drain();

      // Back-to-back mixed-mode stream
      pop_cyc.delete();
      for (int i = 0; i < 8; i++) begin
        issue_rand(1'b0, w);
        check("stream_in_ready_held", 128'(w), 128'(0));
      end
      wait_pops(8);
      check("stream_count", 128'(pop_cyc.size()), 128'(8));
      ok = (pop_cyc.size() == 8);
      for (int i = 1; i < pop_cyc.size(); i++) begin
        if (pop_cyc[i] != pop_cyc[i-1] + 1) ok = 1'b0;
      end
      check("stream_consecutive", 128'(ok), 128'(1));
      wait_drain();

      // Backpressure: stall 6 cycles from the first result of a continuous stream
      fork
        begin
          for (int i = 0; i < 12; i++) issue_rand(1'b0, w);
        end
        begin
          int             t;
          logic [2*W-1:0] held;
          t = 0;
          while (!out_valid && t < 200) begin
            @(posedge CLK);
            #1;
            t++;
          end
          check("stall_first_valid", 128'(out_valid), 128'(1));
          out_ready = 1'b0;
          held = out_z;
          for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            check("stall_out_valid", 128'(out_valid), 128'(1));
            check("stall_out_z_stable", 128'(out_z), 128'(held));
            check("stall_in_ready", 128'(in_ready), 128'(0));
          end
          @(posedge CLK);
          #1;
          out_ready = 1'b1;
        end
      join
      wait_drain();

      // Asynchronous reset mid-cycle with work in flight
      out_ready = 1'b0;
      for (int i = 0; i < n_fill; i++) issue_rand(1'b1, w);
      @(posedge CLK);
      #3;
      RESET = 1'b0;
      #1;
      check("async_reset_out_valid", 128'(out_valid), 128'(0));
      check("async_reset_out_z", 128'(out_z), 128'(0));
      exp_q.delete();
      pop_cyc.delete();
      repeat (2) @(negedge CLK);
      RESET = 1'b1;
      out_ready = 1'b1;
      #1;
      check("post_reset_in_ready", 128'(in_ready), 128'(1));
      repeat (10) @(negedge CLK);
      check("flushed_not_emitted", 128'(pop_cyc.size()), 128'(0));
      @(posedge CLK);
      #1;
      for (int i = 0; i < 4; i++) issue_rand(1'b0, w);
      wait_drain();

      done = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && t < 20000) begin
      @(posedge CLK);
      t++;
    end
    if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done)) begin
      checks++;
      errors++;
      $display("FAIL global_timeout: got unfinished configurations expected all done");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
